seg7_scan_decoder: RTL and testbench

//  Receive end of the multiplexed seven-segment interface. Samples segment lines plus one-hot

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_pattern_decode.sv | 35 +++
 rtl/seg7_scan_decoder.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment table, BCD codes and FSM state type for the 7-seg scan decoder
package seg7_pkg;

    // Segment order is {a,b,c,d,e,f,g}, 1 = lit
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    localparam logic [3:0] BCD_ERR   = 4'hE;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to BCD decode
// SEG7_BLANK_EN: all-dark pattern decodes to BCD_BLANK as a valid digit.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = BCD_ERR;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
`ifdef SEG7_BLANK_EN
            7'h00:   bcd = BCD_BLANK;
`endif
            default: begin
                valid = 1'b0;
                bcd   = BCD_ERR;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers BCD frames from a scanned multiplexed 7-seg bus
// SEG7_BLANK_EN (in seg7_pattern_decode): blank digits are captured without pat_err.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [N_DIGITS-1:0]   dig_sel,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic                  frame_valid,
    output logic                  pat_err,
    output logic                  link_ok
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [6:0]            seg_meta_q, seg_sync_q;
    logic [N_DIGITS-1:0]   sel_meta_q, sel_sync_q;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [6:0]            ref_seg_q, ref_seg_d;
    logic [N_DIGITS-1:0]   ref_sel_q, ref_sel_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
    logic                  fv_q, fv_d;
    logic                  perr_q, perr_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic                  link_q, link_d;

    logic                  dec_valid;
    logic [3:0]            dec_bcd;
    logic                  same, sel_onehot, capture, publish;

    seg7_pattern_decode u_decode (
        .seg   (seg_sync_q),
        .valid (dec_valid),
        .bcd   (dec_bcd)
    );

    assign same       = (seg_sync_q == ref_seg_q) && (sel_sync_q == ref_sel_q);
    assign sel_onehot = (sel_sync_q != '0) && ((sel_sync_q & (sel_sync_q - 1'b1)) == '0);
    assign publish    = &seen_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_seg_d = ref_seg_q;
        ref_sel_d = ref_sel_q;
        capture   = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (sel_onehot) begin
                    state_d   = S_COUNT;
                    cnt_d     = CNT_W'(1);
                    ref_seg_d = seg_sync_q;
                    ref_sel_d = sel_sync_q;
                end
            end
            S_COUNT: begin
                if (same) begin
                    if (cnt_q == CNT_LAST) begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                        cnt_d   = CNT_FULL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sel_onehot) begin
                    cnt_d     = CNT_W'(1);
                    ref_seg_d = seg_sync_q;
                    ref_sel_d = sel_sync_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                // One capture per dwell; any change must go back through S_WAIT
                if (!same) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        seen_d   = publish ? '0 : seen_q;
        bcd_d    = bcd_q;
        fv_d     = 1'b0;
        perr_d   = 1'b0;
        to_d     = to_q;
        link_d   = link_q;
        if (publish) begin
            bcd_d = digits_q;
            fv_d  = 1'b1;
        end
        // A capture on the publish cycle lands in the freshly cleared mask
        if (capture) begin
            perr_d = !dec_valid;
            for (int i = 0; i < N_DIGITS; i++) begin
                if (ref_sel_q[i]) begin
                    digits_d[4*i +: 4] = dec_bcd;
                    seen_d[i]          = 1'b1;
                end
            end
        end
        if (publish) begin
            to_d   = '0;
            link_d = 1'b1;
        end else if (to_q == TO_LAST) begin
            link_d = 1'b0;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_q <= '0;
            seg_sync_q <= '0;
            sel_meta_q <= '0;
            sel_sync_q <= '0;
            state_q    <= S_WAIT;
            cnt_q      <= '0;
            ref_seg_q  <= '0;
            ref_sel_q  <= '0;
            digits_q   <= '0;
            seen_q     <= '0;
            bcd_q      <= '0;
            fv_q       <= 1'b0;
            perr_q     <= 1'b0;
            to_q       <= '0;
            link_q     <= 1'b0;
        end else begin
            seg_meta_q <= seg_in;
            seg_sync_q <= seg_meta_q;
            sel_meta_q <= dig_sel;
            sel_sync_q <= sel_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_seg_q  <= ref_seg_d;
            ref_sel_q  <= ref_sel_d;
            digits_q   <= digits_d;
            seen_q     <= seen_d;
            bcd_q      <= bcd_d;
            fv_q       <= fv_d;
            perr_q     <= perr_d;
            to_q       <= to_d;
            link_q     <= link_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign frame_valid = fv_q;
    assign pat_err     = perr_q;
    assign link_ok     = link_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg_in;
    logic [ND-1:0] dig_sel;
    logic [15:0]   bcd_out;
    logic          frame_valid, pat_err, link_ok;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int pe_cnt = 0;
    logic [15:0] last_frame = '0;

    seg7_scan_decoder #(
        .N_DIGITS       (ND),
        .STABLE_CYCLES  (8),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .pat_err     (pat_err),
        .link_ok     (link_ok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            last_frame = bcd_out;
        end
        if (pat_err) pe_cnt++;
    end

    typedef struct {
        string       name;
        logic [27:0] segs;
        logic [15:0] exp_bcd;
        int          exp_perr;
    } vec_t;

    vec_t vecs[13];
    logic [6:0] seg_tab[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int d, input logic [6:0] s, input int dwell);
        dig_sel = ND'(1 << d);
        seg_in  = s;
        step(dwell);
        dig_sel = '0;
        seg_in  = '0;
        step(2);
    endtask

    initial begin
        int f0, p0, lat, n;

        seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        vecs[0] = '{"scan_4321", {7'h33, 7'h79, 7'h6D, 7'h30}, 16'h4321, 0};
        for (int k = 0; k < 10; k++)
            vecs[1 + k] = '{$sformatf("digit0_%0d", k), {7'h70, 7'h7F, 7'h7B, seg_tab[k]},
                            16'h7890 | 16'(k), 0};
        vecs[11] = '{"bad_49_d1", {7'h30, 7'h30, 7'h49, 7'h7E}, 16'h11E0, 1};
`ifdef SEG7_BLANK_EN
        vecs[12] = '{"dark_d3", {7'h00, 7'h70, 7'h5F, 7'h5B}, 16'hF765, 0};
`else
        vecs[12] = '{"dark_d3", {7'h00, 7'h70, 7'h5F, 7'h5B}, 16'hE765, 1};
`endif

        rst_n   = 1'b0;
        seg_in  = '0;
        dig_sel = '0;
        step(3);
        check("reset_bcd", 32'(bcd_out), 0);
        check("reset_fv", 32'(frame_valid), 0);
        check("reset_perr", 32'(pat_err), 0);
        check("reset_link", 32'(link_ok), 0);
        rst_n = 1'b1;
        step(3);

        foreach (vecs[v]) begin
            f0 = fv_cnt;
            p0 = pe_cnt;
            for (int d = 0; d < ND; d++) show(d, vecs[v].segs[7*d +: 7], 12);
            step(4);
            check({vecs[v].name, "_frames"}, 32'(fv_cnt - f0), 1);
            check({vecs[v].name, "_bcd"}, 32'(last_frame), 32'(vecs[v].exp_bcd));
            check({vecs[v].name, "_perr"}, 32'(pe_cnt - p0), 32'(vecs[v].exp_perr));
            check({vecs[v].name, "_link"}, 32'(link_ok), 1);
        end

        // Short 8 dwell followed by 9 on the same digit: only the 9 may be captured
        f0 = fv_cnt;
        p0 = pe_cnt;
        show(0, 7'h7E, 12);
        show(1, 7'h30, 12);
        show(3, 7'h33, 12);
        dig_sel = 4'b0100;
        seg_in  = 7'h7F;
        step(5);
        seg_in  = 7'h7B;
        step(12);
        dig_sel = '0;
        seg_in  = '0;
        step(6);
        check("glitch_frames", 32'(fv_cnt - f0), 1);
        check("glitch_bcd", 32'(last_frame), 32'h4910);
        check("glitch_perr", 32'(pe_cnt - p0), 0);

        // Multi-hot select must neither capture nor error
        f0 = fv_cnt;
        p0 = pe_cnt;
        show(2, 7'h79, 12);
        show(3, 7'h33, 12);
        dig_sel = 4'b0011;
        seg_in  = 7'h49;
        step(50);
        check("multihot_frames", 32'(fv_cnt - f0), 0);
        check("multihot_perr", 32'(pe_cnt - p0), 0);
        dig_sel = '0;
        seg_in  = '0;
        step(2);
        show(0, 7'h6D, 12);
        show(1, 7'h5B, 12);
        step(4);
        check("multihot_after_frames", 32'(fv_cnt - f0), 1);
        check("multihot_after_bcd", 32'(last_frame), 32'h4352);

        // Pin change to frame_valid on the frame-completing digit
        show(0, 7'h30, 12);
        show(1, 7'h30, 12);
        show(2, 7'h30, 12);
        dig_sel = 4'b1000;
        seg_in  = 7'h7E;
        lat = 0;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            if (frame_valid && lat == 0) lat = k;
        end
        check("latency", 32'(lat), 11);
        check("latency_bcd", 32'(bcd_out), 32'h0111);
        dig_sel = '0;
        seg_in  = '0;
        step(2);

        // Idle bus: link drops after the timeout, data holds
        check("link_before_idle", 32'(link_ok), 1);
        n = 0;
        while (link_ok && n < 400) begin
            step(1);
            n++;
        end
        check("link_drop", 32'(link_ok), 0);
        check("link_drop_window", 32'(n >= 200 && n <= 300), 1);
        check("hold_bcd", 32'(bcd_out), 32'h0111);
        step(20);
        check("hold_link_low", 32'(link_ok), 0);

        // Reset mid-dwell and mid-frame discards partial state
        show(0, 7'h30, 12);
        show(1, 7'h6D, 12);
        dig_sel = 4'b0100;
        seg_in  = 7'h79;
        step(4);
        rst_n = 1'b0;
        step(2);
        check("midrst_bcd", 32'(bcd_out), 0);
        check("midrst_fv", 32'(frame_valid), 0);
        check("midrst_perr", 32'(pat_err), 0);
        check("midrst_link", 32'(link_ok), 0);
        f0 = fv_cnt;
        p0 = pe_cnt;
        rst_n = 1'b1;
        step(12);
        dig_sel = '0;
        seg_in  = '0;
        step(2);
        show(3, 7'h33, 12);
        step(20);
        check("postrst_frames", 32'(fv_cnt - f0), 0);
        check("postrst_perr", 32'(pe_cnt - p0), 0);
        check("postrst_bcd", 32'(bcd_out), 0);
        show(0, 7'h30, 12);
        show(1, 7'h30, 12);
        step(4);
        check("postrst_frame_done", 32'(fv_cnt - f0), 1);
        check("postrst_frame_bcd", 32'(last_frame), 32'h4311);
        check("postrst_link", 32'(link_ok), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
